// File: rtl/fasta_streamer.sv
// FASTA front end for a systolic aligner: loads one query record into a packed register,
// then streams 2-bit encoded database bases with end-of-sequence and inter-sequence reset pulses.
module fasta_streamer #(
  parameter int unsigned QMAX = 50,
  parameter int unsigned LW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_vld,
  output logic              s_rdy,
  output logic [0:2*QMAX-1] o_query,
  output logic [6:0]        o_query_length,
  output logic              o_query_vld,
  output logic              o_vld,
  output logic [1:0]        o_data,
  output logic              o_eos,
  output logic              o_seq_rst,
  output logic [LW-1:0]     o_db_len,
  output logic [LW-1:0]     o_rec_cnt,
  output logic              o_err
);

  typedef enum logic [2:0] {Q_HDR, Q_SEQ, D_WAIT, D_HDR, D_SEQ, FLUSH} state_t;

  state_t              r_state, w_state_d;
  logic [0:2*QMAX-1]   r_query;
  logic [6:0]          r_qcnt;
  logic [6:0]          r_qlen;
  logic                r_qvld;
  logic                r_vld;
  logic [1:0]          r_data;
  logic                r_eos;
  logic                r_hdr_pend;
  logic [LW-1:0]       r_db_len;
  logic [LW-1:0]       r_rec_cnt;
  logic                r_err;

  logic                w_hs;
  logic                w_byte;
  logic                w_lf;
  logic                w_cr;
  logic                w_gt;
  logic                w_is_base;
  logic [1:0]          w_code;

  assign w_hs   = s_vld & s_rdy;
  assign w_lf   = (s_data == 8'h0A);
  assign w_cr   = (s_data == 8'h0D);
  assign w_gt   = (s_data == 8'h3E);
  assign w_byte = w_hs & ~w_cr;

  always_comb begin
    w_is_base = 1'b0;
    w_code    = 2'b00;
    case (s_data)
      8'h41, 8'h61: begin w_is_base = 1'b1; w_code = 2'b00; end
      8'h47, 8'h67: begin w_is_base = 1'b1; w_code = 2'b01; end
      8'h54, 8'h74: begin w_is_base = 1'b1; w_code = 2'b10; end
      8'h43, 8'h63: begin w_is_base = 1'b1; w_code = 2'b11; end
      default: ;
    endcase
  end

  // The o_eos cycle sits in D_WAIT with r_eos high; a '>' accepted there is remembered
  // in r_hdr_pend so FLUSH can resume in D_HDR without stalling the source a second cycle.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      Q_HDR:  if (w_byte && w_lf) w_state_d = Q_SEQ;
      Q_SEQ:  if (w_byte && w_lf && r_qcnt != 7'd0) w_state_d = D_WAIT;
      D_WAIT: begin
        if (r_eos) w_state_d = FLUSH;
        else if (w_byte && w_gt) w_state_d = D_HDR;
      end
      D_HDR:  if (w_byte && w_lf) w_state_d = D_SEQ;
      D_SEQ:  if (w_byte && w_lf && r_db_len != '0) w_state_d = D_WAIT;
      FLUSH:  w_state_d = r_hdr_pend ? D_HDR : D_WAIT;
      default: w_state_d = Q_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= Q_HDR;
      r_query    <= '0;
      r_qcnt     <= 7'd0;
      r_qlen     <= 7'd0;
      r_qvld     <= 1'b0;
      r_vld      <= 1'b0;
      r_data     <= 2'b00;
      r_eos      <= 1'b0;
      r_hdr_pend <= 1'b0;
      r_db_len   <= '0;
      r_rec_cnt  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_vld   <= 1'b0;
      r_eos   <= 1'b0;
      if (r_state == D_WAIT && r_eos) r_hdr_pend <= w_byte & w_gt;
      if (w_byte) begin
        case (r_state)
          Q_SEQ: begin
            if (w_lf) begin
              if (r_qcnt == 7'd0) begin
                r_err <= 1'b1;
              end else begin
                r_qvld <= 1'b1;
                r_qlen <= r_qcnt - 7'd1;
              end
            end else if (w_is_base && r_qcnt < 7'(QMAX)) begin
              for (int unsigned k = 0; k < QMAX; k++) begin
                if (r_qcnt == 7'(k)) r_query[2*k +: 2] <= w_code;
              end
              r_qcnt <= r_qcnt + 7'd1;
            end else begin
              r_err <= 1'b1;
            end
          end
          D_WAIT: if (!w_gt && !w_lf) r_err <= 1'b1;
          D_HDR:  if (w_lf) r_db_len <= '0;
          D_SEQ: begin
            if (w_is_base) begin
              r_vld  <= 1'b1;
              r_data <= w_code;
              if (r_db_len != '1) r_db_len <= r_db_len + LW'(1);
            end else if (w_lf) begin
              if (r_db_len != '0) begin
                r_eos     <= 1'b1;
                r_rec_cnt <= r_rec_cnt + LW'(1);
              end
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign s_rdy          = (r_state != FLUSH);
  assign o_seq_rst      = (r_state == FLUSH);
  assign o_query        = r_query;
  assign o_query_length = r_qlen;
  assign o_query_vld    = r_qvld;
  assign o_vld          = r_vld;
  assign o_data         = r_data;
  assign o_eos          = r_eos;
  assign o_db_len       = r_db_len;
  assign o_rec_cnt      = r_rec_cnt;
  assign o_err          = r_err;

endmodule

// File: tb/tb_fasta_streamer.sv
// Scoreboard bench for fasta_streamer: directed FASTA streams, expected strobes queued at
// handshake time and checked by an independent monitor; level outputs checked directly.
module tb_fasta_streamer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   s_data = 8'h00;
  logic         s_vld = 1'b0;
  logic         s_rdy;
  logic [0:99]  o_query;
  logic [6:0]   o_query_length;
  logic         o_query_vld, o_vld, o_eos, o_seq_rst, o_err;
  logic [1:0]   o_data;
  logic [15:0]  o_db_len, o_rec_cnt;

  logic         s_rdy4;
  logic [0:7]   o_query4;
  logic [6:0]   o_query_length4;
  logic         o_query_vld4, o_vld4, o_eos4, o_seq_rst4, o_err4;
  logic [1:0]   o_data4;
  logic [15:0]  o_db_len4, o_rec_cnt4;

  always #5 clk = ~clk;

  fasta_streamer u_dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .o_query(o_query), .o_query_length(o_query_length), .o_query_vld(o_query_vld),
    .o_vld(o_vld), .o_data(o_data), .o_eos(o_eos), .o_seq_rst(o_seq_rst),
    .o_db_len(o_db_len), .o_rec_cnt(o_rec_cnt), .o_err(o_err)
  );

  fasta_streamer #(.QMAX(4)) u_dut4 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy4),
    .o_query(o_query4), .o_query_length(o_query_length4), .o_query_vld(o_query_vld4),
    .o_vld(o_vld4), .o_data(o_data4), .o_eos(o_eos4), .o_seq_rst(o_seq_rst4),
    .o_db_len(o_db_len4), .o_rec_cnt(o_rec_cnt4), .o_err(o_err4)
  );

  typedef struct packed {
    logic [1:0] kind;  // 0 base, 1 eos, 2 seq_rst
    logic [1:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   rdy_low = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push(input logic [1:0] k, input logic [1:0] d, input int c);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per output strobe
  initial begin
    exp_t       e;
    logic [1:0] k;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!s_rdy) rdy_low++;
        if (int'(o_vld) + int'(o_eos) + int'(o_seq_rst) > 1) begin
          nvec++;
          nfail++;
          $display("FAIL strobe_overlap: vld=%0b eos=%0b seq_rst=%0b at cycle %0d, want at most one",
                   o_vld, o_eos, o_seq_rst, cyc);
        end
        if (o_vld || o_eos || o_seq_rst) begin
          k = o_vld ? 2'd0 : (o_eos ? 2'd1 : 2'd2);
          nvec++;
          if (sb.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_strobe: kind=%0d data=%b at cycle %0d, want no strobe",
                     k, o_data, cyc);
          end else begin
            e = sb.pop_front();
            if (e.kind !== k || e.cyc != cyc || (k == 2'd0 && o_data !== e.data) ||
                (k == 2'd2 && s_rdy !== 1'b0)) begin
              nfail++;
              $display("FAIL strobe: got kind=%0d data=%b cyc=%0d s_rdy=%0b, want kind=%0d data=%b cyc=%0d",
                       k, o_data, cyc, s_rdy, e.kind, e.data, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Call at a negedge; x is the hand-computed outcome: A/C/G/T base, E end of record, - nothing
  task automatic send_byte(input logic [7:0] b, input logic [7:0] x);
    int n;
    n = 0;
    s_data = b;
    s_vld  = 1'b1;
    while (!s_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy) begin
      nvec++;
      nfail++;
      $display("FAIL hs_timeout: s_rdy=0 for %0d cycles, want 1", n);
    end else begin
      case (x)
        "A": push(2'd0, 2'b00, cyc + 1);
        "G": push(2'd0, 2'b01, cyc + 1);
        "T": push(2'd0, 2'b10, cyc + 1);
        "C": push(2'd0, 2'b11, cyc + 1);
        "E": begin
          push(2'd1, 2'b00, cyc + 1);
          push(2'd2, 2'b00, cyc + 2);
        end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic send_str(input string s, input string e);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], e[i]);
  endtask

  task automatic idle(input int n);
    s_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_query"}, o_query, '0);
    chk({tag, "_qlen"}, o_query_length, 0);
    chk({tag, "_qvld"}, o_query_vld, 0);
    chk({tag, "_strobes"}, {o_vld, o_data, o_eos, o_seq_rst}, 0);
    chk({tag, "_db_len"}, o_db_len, 0);
    chk({tag, "_rec_cnt"}, o_rec_cnt, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_s_rdy"}, s_rdy, 1);
  endtask

  task automatic do_reset();
    chk("drain_before_reset", sb.size(), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    s_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [0:99] eq;
    int          low0;

    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    // Query load
    send_str(">q\nACGT\n", "--------");
    idle(2);
    eq = '0;
    eq[0:7] = 8'b00110110;
    chk("q_query", o_query, eq);
    chk("q_qlen", o_query_length, 3);
    chk("q_qvld", o_query_vld, 1);
    chk("q_err", o_err, 0);

    // First database record
    send_str(">d1\nTTA\n", "----TTAE");
    idle(4);
    chk("d1_db_len", o_db_len, 3);
    chk("d1_rec_cnt", o_rec_cnt, 1);
    chk("d1_err", o_err, 0);
    chk("d1_drain", sb.size(), 0);

    // Blank line, CR and bad bytes inside a record
    send_str(">d2\n\nAC\rN G\n", "-----AC---GE");
    idle(4);
    chk("d2_db_len", o_db_len, 3);
    chk("d2_rec_cnt", o_rec_cnt, 2);
    chk("d2_err", o_err, 1);
    chk("d2_drain", sb.size(), 0);

    // Back-to-back records with s_vld held high
    low0 = rdy_low;
    send_str(">e\nGA\n>f\nC\n", "---GAE---CE");
    idle(4);
    chk("b2b_rdy_low", rdy_low - low0, 2);
    chk("b2b_rec_cnt", o_rec_cnt, 4);
    chk("b2b_db_len", o_db_len, 1);
    chk("b2b_drain", sb.size(), 0);

    // Reset in the middle of a record
    send_str(">g\nTT", "---TT");
    idle(1);
    #2 rst = 1'b1;
    s_vld = 1'b0;
    #1 chk_reset("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_drain", sb.size(), 0);
    send_str(">q\nC\n", "-----");
    idle(2);
    eq = '0;
    eq[0:1] = 2'b11;
    chk("rq_query", o_query, eq);
    chk("rq_qlen", o_query_length, 0);
    chk("rq_qvld", o_query_vld, 1);
    chk("rq_err", o_err, 0);

    // Query overflow against the QMAX=4 instance
    do_reset();
    send_str(">q\nACGTA\n", "---------");
    idle(2);
    chk("ov4_query", o_query4, 8'b00110110);
    chk("ov4_qlen", o_query_length4, 3);
    chk("ov4_err", o_err4, 1);
    chk("ov4_qvld", o_query_vld4, 1);
    chk("ov50_qlen", o_query_length, 4);
    chk("ov50_err", o_err, 0);

    // Empty query line
    do_reset();
    send_str(">q\n\n", "----");
    idle(2);
    chk("eq_err", o_err, 1);
    chk("eq_qvld", o_query_vld, 0);
    send_str("A\n", "--");
    idle(2);
    chk("eq2_qvld", o_query_vld, 1);
    chk("eq2_qlen", o_query_length, 0);
    chk("eq2_query", o_query, '0);
    chk("end_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
